mp_subtractor: RTL and testbench
================================

// Module: mp_subtractor
// PURPOSE
//   Word-serial multi-precision subtractor: oRes = iOpA - iOpB over OPERAND_WIDTH bits,
//   one WORD_WIDTH-bit slice per cycle, LSW first, borrow chained via a carry register.
//   Reports the sign of the difference on oNeg; optionally returns |A-B| via a second
//   word-serial negate pass. Counterpart to the multi-precision adder in the arithmetic
//   datapath (modular reduction, compare-and-subtract steps).
// PARAMETERS
//   OPERAND_WIDTH  512                          operand/result width; multiple of WORD_WIDTH
//   WORD_WIDTH     32                           width of the combinational subtract slice
//   N_WORDS        OPERAND_WIDTH/WORD_WIDTH     iterations per pass (derived)
// PORTS
//   iClk     in   1              clock, rising edge
//   iRst     in   1              reset, synchronous, active-high
//   iStart   in   1              start request; sampled only in IDLE
//   iOpA     in   OPERAND_WIDTH  minuend; captured on accepting edge
//   iOpB     in   OPERAND_WIDTH  subtrahend; captured on accepting edge
//   oRes     out  OPERAND_WIDTH  difference (raw two's complement, or magnitude, see CONFIG)
//   oNeg     out  1              1 = A < B (unsigned), i.e. final borrow of the SUB pass
//   oBusy    out  1              1 in SUB and FIX states
//   oDone    out  1              single-cycle pulse: oRes/oNeg valid
// BEHAVIOUR
//   Reset: state IDLE, counter 0, oRes=0, oNeg=0, oBusy=0, oDone=0, carry reg=0.
//   States: IDLE, SUB, FIX, DONE.
//   IDLE: iStart=1 -> capture iOpA into A shift reg, ~iOpB into B shift reg, cnt=0,
//     carry=1 (two's-complement +1), -> SUB. iStart=0 -> stay; oRes/oNeg hold.
//   SUB: slice = A[W-1:0] + B[W-1:0] + carry; sum shifted into result reg at MSW end,
//     result reg shifts right by WORD_WIDTH; A, B shift right by WORD_WIDTH (zero fill);
//     carry <= slice carry-out. cnt increments; after N_WORDS cycles (cnt==N_WORDS-1):
//     oNeg <= ~carry_out of last slice; next = FIX if macro on and borrow, else DONE.
//   FIX: carry preset to 1 on entry; slice = ~Res[W-1:0] + carry; result reg rotates
//     (new word in at MSW end); N_WORDS cycles, then -> DONE. oNeg unchanged.
//   DONE: oDone=1 for exactly this cycle; -> IDLE. oBusy=0.
//   Latency (accept edge = edge 0): oDone high in cycle N_WORDS+1 without FIX,
//     2*N_WORDS+1 with FIX. Result register frozen outside SUB/FIX: oRes/oNeg hold
//     until next accepted start.
//   iStart while not IDLE: ignored, no queuing. iStart held high: new op accepted on the
//     IDLE cycle following DONE (back-to-back, one idle cycle minimum).
//   Counter width $clog2(N_WORDS)+1; counter cleared on every pass entry.
//   A == B: oRes=0, oNeg=0, FIX never entered. Unsigned magnitude always fits in
//     OPERAND_WIDTH bits (no overflow case).
//   iRst mid-operation: abort at next edge, all state/outputs to reset values; no oDone.
// CONFIGURATION
//   MP_SUB_ABS_EN defined: borrow at end of SUB enters FIX; oRes = |A - B|.
//   MP_SUB_ABS_EN undefined: FIX state and negate logic not built; oRes = (A - B)
//     mod 2^OPERAND_WIDTH; oNeg still reports borrow; latency always N_WORDS+1.
// TESTING  (bench uses OPERAND_WIDTH=128, WORD_WIDTH=32, N_WORDS=4)
//   1. A=0x..0005, B=0x..0003 -> oRes=2, oNeg=0, oDone in cycle 5 after accept, either config.
//   2. A=0, B=1 -> oNeg=1; no macro: oRes=all-ones, oDone cycle 5; ABS_EN: oRes=1, oDone cycle 9.
//   3. A=2^96, B=1 -> oRes=0x00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, oNeg=0 (borrow across 3 words).
//   4. A=B=random 128-bit -> oRes=0, oNeg=0, no FIX; then 200 random pairs vs reference model.
//   5. iStart pulsed during SUB, and iRst asserted mid-SUB -> ignored / outputs 0, no oDone,
//      next start after reset yields correct result.
//   6. iStart held high continuously -> one oDone per N_WORDS+2 cycles, oRes stable between.

Source files
------------

// File: rtl/mp_subtractor.sv
// rtl/mp_subtractor.sv - word-serial multi-precision subtractor, optional |A-B| via MP_SUB_ABS_EN
// The working register holds A on entry and collects the difference as A's words are consumed.
module mp_subtractor #(
    parameter int OPERAND_WIDTH = 512,
    parameter int WORD_WIDTH    = 32
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iStart,
    input  logic [OPERAND_WIDTH-1:0] iOpA,
    input  logic [OPERAND_WIDTH-1:0] iOpB,
    output logic [OPERAND_WIDTH-1:0] oRes,
    output logic                     oNeg,
    output logic                     oBusy,
    output logic                     oDone
);
    localparam int N_WORDS = OPERAND_WIDTH / WORD_WIDTH;
    localparam int CW      = $clog2(N_WORDS) + 1;
    localparam int OW      = OPERAND_WIDTH;
    localparam int W       = WORD_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_SUB, S_FIX, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic [OW-1:0]   work_q, work_d;
    logic [OW-1:0]   b_q, b_d;
    logic [OW-1:0]   out_q, out_d;
    logic            neg_q, neg_d;
    logic [W:0]      slice;
    logic [OW-1:0]   work_next;
    logic            last;

    assign last = (cnt_q == CW'(N_WORDS - 1));

    // One slice adder serves both passes; FIX negates the stored difference word.
    always_comb begin
        slice = {1'b0, work_q[W-1:0]} + {1'b0, b_q[W-1:0]} + {{W{1'b0}}, carry_q};
`ifdef MP_SUB_ABS_EN
        if (state_q == S_FIX) begin
            slice = {1'b0, ~work_q[W-1:0]} + {{W{1'b0}}, carry_q};
        end
`endif
        work_next = {slice[W-1:0], work_q[OW-1:W]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        work_d  = work_q;
        b_d     = b_q;
        out_d   = out_q;
        neg_d   = neg_q;
        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    work_d  = iOpA;
                    b_d     = ~iOpB;
                    cnt_d   = '0;
                    carry_d = 1'b1;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                work_d  = work_next;
                b_d     = {{W{1'b0}}, b_q[OW-1:W]};
                carry_d = slice[W];
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    neg_d = ~slice[W];
                    cnt_d = '0;
`ifdef MP_SUB_ABS_EN
                    if (!slice[W]) begin
                        carry_d = 1'b1;
                        state_d = S_FIX;
                    end else begin
                        out_d   = work_next;
                        state_d = S_DONE;
                    end
`else
                    out_d   = work_next;
                    state_d = S_DONE;
`endif
                end
            end
`ifdef MP_SUB_ABS_EN
            S_FIX: begin
                work_d  = work_next;
                carry_d = slice[W];
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    cnt_d   = '0;
                    out_d   = work_next;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            work_q  <= '0;
            b_q     <= '0;
            out_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            work_q  <= work_d;
            b_q     <= b_d;
            out_q   <= out_d;
            neg_q   <= neg_d;
        end
    end

    assign oRes  = out_q;
    assign oNeg  = neg_q;
    assign oBusy = (state_q == S_SUB) || (state_q == S_FIX);
    assign oDone = (state_q == S_DONE);
endmodule

// File: tb/tb_mp_subtractor.sv
// tb/tb_mp_subtractor.sv - directed and random checks of mp_subtractor at 128/32 bits
module tb_mp_subtractor;
    localparam int OW = 128;
    localparam int W  = 32;
    localparam int N  = OW / W;
`ifdef MP_SUB_ABS_EN
    localparam bit ABS_EN = 1'b1;
`else
    localparam bit ABS_EN = 1'b0;
`endif

    logic          iClk = 1'b0;
    logic          iRst = 1'b1;
    logic          iStart = 1'b0;
    logic [OW-1:0] iOpA = '0;
    logic [OW-1:0] iOpB = '0;
    logic [OW-1:0] oRes;
    logic          oNeg, oBusy, oDone;

    int checks = 0;
    int failures = 0;

    mp_subtractor #(.OPERAND_WIDTH(OW), .WORD_WIDTH(W)) dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iOpA(iOpA), .iOpB(iOpB),
        .oRes(oRes), .oNeg(oNeg), .oBusy(oBusy), .oDone(oDone)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits for oDone from the negedge of cycle `start_cyc`; returns cycle index or 0 on timeout.
    task automatic wait_done(input int start_cyc, output int done_cyc);
        int cyc;
        cyc = start_cyc;
        done_cyc = 0;
        while (cyc < 40 && done_cyc == 0) begin
            if (oDone === 1'b1) done_cyc = cyc;
            else begin
                @(negedge iClk);
                cyc++;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [OW-1:0] a, input logic [OW-1:0] b,
                          input logic [OW-1:0] exp_res, input logic exp_neg, input int exp_lat);
        int dc;
        @(negedge iClk);
        iStart = 1'b1; iOpA = a; iOpB = b;
        @(negedge iClk);
        iStart = 1'b0;
        check({tag, "_busy"}, {127'd0, oBusy}, 128'd1);
        wait_done(1, dc);
        check({tag, "_lat"}, OW'(dc), OW'(exp_lat));
        check({tag, "_res"}, oRes, exp_res);
        check({tag, "_neg"}, {127'd0, oNeg}, {127'd0, exp_neg});
        @(negedge iClk);
        check({tag, "_pulse"}, {127'd0, oDone}, 128'd0);
    endtask

    initial begin
        logic [OW-1:0] a, b, d, er;
        logic          en;
        int            dc;
        int            dones[$];
        int            seen;

        repeat (2) @(negedge iClk);
        check("rst_res", oRes, '0);
        check("rst_flags", {125'd0, oNeg, oBusy, oDone}, '0);
        iRst = 1'b0;

        run_op("t1", 128'd5, 128'd3, 128'd2, 1'b0, N + 1);
        run_op("t2", 128'd0, 128'd1, ABS_EN ? 128'd1 : {OW{1'b1}}, 1'b1, ABS_EN ? 2*N + 1 : N + 1);
        a = 128'd1 << 96;
        run_op("t3", a, 128'd1, 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b0, N + 1);
        a = {$urandom, $urandom, $urandom, $urandom};
        run_op("t4_eq", a, a, 128'd0, 1'b0, N + 1);

        for (int i = 0; i < 200; i++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            if (i % 4 == 0) b[OW-1:W] = a[OW-1:W];
            d  = a - b;
            en = (a < b);
            er = (ABS_EN && en) ? (b - a) : d;
            run_op("rnd", a, b, er, en, (ABS_EN && en) ? 2*N + 1 : N + 1);
        end

        // Start request during SUB is ignored
        @(negedge iClk);
        iStart = 1'b1; iOpA = 128'd10; iOpB = 128'd4;
        @(negedge iClk);
        iStart = 1'b0;
        @(negedge iClk);
        iStart = 1'b1; iOpA = 128'd100; iOpB = 128'd1;
        @(negedge iClk);
        iStart = 1'b0;
        wait_done(3, dc);
        check("t5_ign_lat", OW'(dc), OW'(N + 1));
        check("t5_ign_res", oRes, 128'd6);
        @(negedge iClk);

        // Reset mid-SUB aborts with no oDone
        @(negedge iClk);
        iStart = 1'b1; iOpA = 128'd0; iOpB = 128'd1;
        @(negedge iClk);
        iStart = 1'b0;
        @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        check("t5_rst_res", oRes, '0);
        check("t5_rst_flags", {125'd0, oNeg, oBusy, oDone}, '0);
        seen = 0;
        repeat (12) begin
            @(negedge iClk);
            if (oDone === 1'b1) seen++;
        end
        check("t5_rst_nodone", OW'(seen), '0);
        run_op("t5_after", 128'd7, 128'd9, ABS_EN ? 128'd2 : -128'sd2, 1'b1, ABS_EN ? 2*N + 1 : N + 1);

        // iStart held high: back-to-back operations
        @(negedge iClk);
        iStart = 1'b1; iOpA = 128'd5; iOpB = 128'd3;
        for (int c = 0; c < 30; c++) begin
            @(negedge iClk);
            if (oDone === 1'b1) dones.push_back(c);
            if (dones.size() > 0) check("t6_stable", oRes, 128'd2);
        end
        iStart = 1'b0;
        check("t6_count", OW'(dones.size() >= 3), 128'd1);
        for (int k = 1; k < dones.size(); k++)
            check("t6_period", OW'(dones[k] - dones[k-1]), OW'(N + 2));
        repeat (2 * N + 4) @(negedge iClk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
